mdr_cmd_master: RTL and testbench

MDR_CMD_MASTER -- requirements
Module: mdr_cmd_master

---
 rtl/mdr_pkg.sv | 22 ++
 rtl/mdr_timeout_cnt.sv | 39 +++
 rtl/mdr_cmd_master.sv | 154 +++++++++++++++
 tb/tb_mdr_cmd_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared definitions for the MDR command master: FSM states, opcode type and
// default sizing.
package mdr_pkg;

    localparam int MDR_DW      = 16;
    localparam int MDR_TIMEOUT = 1024;

    typedef logic [1:0]        mdr_op_t;
    typedef logic [MDR_DW-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_X,
        LOAD_X,
        WAIT_Y,
        LOAD_Y,
        BUSY,
        RESP
    } state_e;

endpackage

// File: rtl/mdr_timeout_cnt.sv
// Watchdog counter for the command master: cleared per command, counts while
// enabled and saturates at TIMEOUT-1, which it flags on tc.
module mdr_timeout_cnt
    import mdr_pkg::*;
#(
    parameter int TIMEOUT = MDR_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

    // Saturating so a stalled master never wraps back below the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mdr_cmd_master.sv
// Command master for the multiply/divide unit: accepts a command, sequences
// start and operand loads, waits for the result and holds a response.
module mdr_cmd_master
    import mdr_pkg::*;
#(
    parameter int DW      = MDR_DW,
    parameter int TIMEOUT = MDR_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_x,
    input  logic [DW-1:0] cmd_y,
    output logic [1:0]    mdr_op,
    output logic [DW-1:0] mdr_data,
    output logic          mdr_load,
    output logic          mdr_start,
    input  logic          mdr_load_x,
    input  logic          mdr_load_y,
    input  logic          mdr_ready,
    input  logic          mdr_error,
    input  logic [DW-1:0] mdr_result,
    input  logic [DW-1:0] mdr_remainder,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_result,
    output logic [DW-1:0] rsp_remainder,
    output logic          rsp_error,
    output logic          rsp_timeout
);

    state_e        state_q, state_d;
    mdr_op_t       op_q, op_d;
    logic [DW-1:0] x_q, x_d, y_q, y_d, data_q, data_d;
    logic [DW-1:0] res_q, res_d, rem_q, rem_d;
    logic          err_q, err_d, to_q, to_d;
    logic          cnt_en, cnt_tc;

    mdr_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == IDLE),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    // Forward progress (operand request or result) always wins over the watchdog.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        res_d   = res_q;
        rem_d   = rem_q;
        err_d   = err_q;
        to_d    = to_q;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    state_d = START;
                end
            end
            START:  state_d = WAIT_X;
            WAIT_X: begin
                cnt_en = 1'b1;
                if (mdr_load_x) begin
                    data_d  = x_q;
                    state_d = LOAD_X;
                end else if (cnt_tc) begin
                    state_d = RESP;
                end
            end
            LOAD_X: state_d = WAIT_Y;
            WAIT_Y: begin
                cnt_en = 1'b1;
                if (mdr_load_y) begin
                    data_d  = y_q;
                    state_d = LOAD_Y;
                end else if (cnt_tc) begin
                    state_d = RESP;
                end
            end
            LOAD_Y: state_d = BUSY;
            BUSY: begin
                cnt_en = 1'b1;
                if (mdr_ready) begin
                    res_d   = mdr_result;
                    rem_d   = mdr_remainder;
                    err_d   = mdr_error;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (cnt_tc) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cnt_en && cnt_tc && state_d == RESP && !(state_q == BUSY && mdr_ready)) begin
            res_d = '0;
            rem_d = '0;
            err_d = 1'b1;
            to_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // cmd_ready is gated by rst so every output reads 0 while reset is held.
    assign cmd_ready     = (state_q == IDLE) && rst;
    assign mdr_start     = (state_q == START);
    assign mdr_load      = (state_q == LOAD_X) || (state_q == LOAD_Y);
    assign mdr_op        = op_q;
    assign mdr_data      = data_q;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_result    = res_q;
    assign rsp_remainder = rem_q;
    assign rsp_error     = err_q;
    assign rsp_timeout   = to_q;

endmodule

// File: tb/tb_mdr_cmd_master.sv
// Self-checking bench for mdr_cmd_master: a behavioural MDR model plus a
// vector table and directed sequences for timeout and mid-operation reset.
module tb_mdr_cmd_master;

    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk, rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_x, cmd_y;
    logic [1:0]    mdr_op;
    logic [DW-1:0] mdr_data;
    logic          mdr_load, mdr_start;
    logic          mdr_load_x, mdr_load_y, mdr_ready, mdr_error;
    logic [DW-1:0] mdr_result, mdr_remainder;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_result, rsp_remainder;
    logic          rsp_error, rsp_timeout;

    int checks = 0;
    int errors = 0;

    mdr_cmd_master #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .mdr_op        (mdr_op),
        .mdr_data      (mdr_data),
        .mdr_load      (mdr_load),
        .mdr_start     (mdr_start),
        .mdr_load_x    (mdr_load_x),
        .mdr_load_y    (mdr_load_y),
        .mdr_ready     (mdr_ready),
        .mdr_error     (mdr_error),
        .mdr_result    (mdr_result),
        .mdr_remainder (mdr_remainder),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_remainder (rsp_remainder),
        .rsp_error     (rsp_error),
        .rsp_timeout   (rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MDR: op0 multiply (low/high halves), op1 divide, others add/sub.
    logic          ready_en, force_ready;
    int            nloads;
    logic [DW-1:0] mx, my;
    logic [31:0]   prod;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            nloads <= 0;
            mx     <= '0;
            my     <= '0;
        end else if (mdr_start) begin
            nloads <= 0;
        end else if (mdr_load) begin
            if (nloads == 0) mx <= mdr_data;
            else             my <= mdr_data;
            nloads <= nloads + 1;
        end
    end

    always_comb begin
        prod          = 32'(mx) * 32'(my);
        mdr_ready     = force_ready | (ready_en & (nloads == 2));
        mdr_error     = 1'b0;
        mdr_result    = '0;
        mdr_remainder = '0;
        case (mdr_op)
            2'd0: begin
                mdr_result    = prod[15:0];
                mdr_remainder = prod[31:16];
            end
            2'd1: begin
                if (my == '0) mdr_error = 1'b1;
                else begin
                    mdr_result    = mx / my;
                    mdr_remainder = mx % my;
                end
            end
            default: begin
                mdr_result    = mx + my;
                mdr_remainder = mx - my;
            end
        endcase
    end

    // Strobe monitor, sampled mid-cycle.
    int            start_cnt = 0;
    int            load_cnt  = 0;
    int            overlap_cnt = 0;
    logic [1:0]    seen_op;
    logic [DW-1:0] load_data [64];

    always @(negedge clk) begin
        if (mdr_start) begin
            start_cnt = start_cnt + 1;
            seen_op   = mdr_op;
        end
        if (mdr_load) begin
            load_data[load_cnt % 64] = mdr_data;
            load_cnt = load_cnt + 1;
        end
        if (mdr_start && mdr_load) overlap_cnt = overlap_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("cmd_ready_before_send", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Response consumed with a new command offered in the same cycle; it must not be taken.
    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("consume_state", {61'd0, rsp_valid, cmd_ready, mdr_start}, {61'd0, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [DW-1:0] x,
                                 input logic [DW-1:0] y, input int hold, input logic frc,
                                 input logic [DW-1:0] e_res, input logic [DW-1:0] e_rem,
                                 input logic e_err);
        int s0, l0, lat;
        s0 = start_cnt;
        l0 = load_cnt;
        force_ready = frc;
        ready_en    = 1'b1;
        sendCmd(op, x, y);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        force_ready = 1'b0;
        checkOutput({name, "_latency"}, 64'(lat), 64'd6);
        checkOutput({name, "_starts"}, 64'(start_cnt - s0), 64'd1);
        checkOutput({name, "_loads"}, 64'(load_cnt - l0), 64'd2);
        checkOutput({name, "_load_data"}, {32'd0, load_data[l0 % 64], load_data[(l0 + 1) % 64]}, {32'd0, x, y});
        checkOutput({name, "_op"}, {62'd0, seen_op}, {62'd0, op});
        checkOutput({name, "_rsp"}, {30'd0, rsp_result, rsp_remainder, rsp_error, rsp_timeout},
                    {30'd0, e_res, e_rem, e_err, 1'b0});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({name, "_hold"}, {29'd0, rsp_valid, rsp_result, rsp_remainder, rsp_error, rsp_timeout},
                        {29'd0, 1'b1, e_res, e_rem, e_err, 1'b0});
        end
        consume();
    endtask

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [DW-1:0] x, y;
        int            hold;
        logic          frc;
        logic [DW-1:0] e_res, e_rem;
        logic          e_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int waiting;
        int s0, l0, seen_rsp;

        vecs[0] = '{"mul_7x6",      2'd0, 16'd7,      16'd6,      0, 1'b0, 16'd42,    16'd0,     1'b0};
        vecs[1] = '{"div_100_7",    2'd1, 16'd100,    16'd7,      5, 1'b0, 16'd14,    16'd2,     1'b0};
        vecs[2] = '{"div_by_zero",  2'd1, 16'd5,      16'd0,      1, 1'b0, 16'd0,     16'd0,     1'b1};
        vecs[3] = '{"mul_overflow", 2'd0, 16'd300,    16'd300,    0, 1'b1, 16'd24464, 16'd1,     1'b0};
        vecs[4] = '{"div_max",      2'd1, 16'hFFFF,   16'd256,    2, 1'b0, 16'd255,   16'd255,   1'b0};
        vecs[5] = '{"op3_passthru", 2'd3, 16'h00F0,   16'h0F0F,   0, 1'b1, 16'h0FFF,  16'hF1E1,  1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
        rsp_ready = 1'b0; mdr_load_x = 1'b1; mdr_load_y = 1'b1;
        ready_en = 1'b1; force_ready = 1'b0;
        #2 rst = 1'b0;
        #20;
        checkOutput("reset_outputs",
                    {8'd0, cmd_ready, mdr_op, mdr_data, mdr_load, mdr_start, rsp_valid,
                     rsp_result, rsp_remainder, rsp_error, rsp_timeout}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

        // Timeout: the MDR never answers; WAIT_X + WAIT_Y + BUSY must total TIMEOUT cycles.
        ready_en = 1'b0;
        sendCmd(2'd0, 16'd11, 16'd13);
        waiting = 0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            if (!mdr_start && !mdr_load) waiting++;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("timeout_wait_cycles", 64'(waiting), 64'(TO));
        checkOutput("timeout_rsp", {30'd0, rsp_valid, rsp_result, rsp_remainder, rsp_error, rsp_timeout},
                    {30'd0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b1});
        consume();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].hold,
                          vecs[i].frc, vecs[i].e_res, vecs[i].e_rem, vecs[i].e_err);
        end

        // Reset while BUSY: everything drops at once and nothing resumes afterwards.
        ready_en = 1'b0;
        sendCmd(2'd1, 16'd9, 16'd3);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checkOutput("midreset_outputs",
                    {8'd0, cmd_ready, mdr_op, mdr_data, mdr_load, mdr_start, rsp_valid,
                     rsp_result, rsp_remainder, rsp_error, rsp_timeout}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ready_en = 1'b1;
        #1;
        checkOutput("midreset_ready", {63'd0, cmd_ready}, 64'd1);
        s0 = start_cnt;
        l0 = load_cnt;
        seen_rsp = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid) seen_rsp++;
        end
        checkOutput("midreset_quiet", {32'(start_cnt - s0), 32'(load_cnt - l0 + seen_rsp)}, 64'd0);
        applyStimulus("mul_3x4_after_reset", 2'd0, 16'd3, 16'd4, 0, 1'b0, 16'd12, 16'd0, 1'b0);

        checkOutput("no_start_load_overlap", 64'(overlap_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
